// File: rtl/nap_timer_pkg.sv
`default_nettype none
// ============================================================================
// Package  : nap_timer_pkg
// Brief    : Shared types, BCD digit limits and time helpers for nap_timer_bank
// Revision : 1.0 - initial release
// ============================================================================
package nap_timer_pkg;

    typedef enum logic [2:0] {
        CH_IDLE   = 3'd0,
        CH_LOADED = 3'd1,
        CH_RUN    = 3'd2,
        CH_PAUSE  = 3'd3,
        CH_RING   = 3'd4
    } chan_state_e;

    // {H10,H1,M10,M1,S10,S1}, one BCD nibble per digit
    typedef logic [23:0] bcd_time_t;

    localparam logic [3:0] c_DIGIT_MAX    = 4'd9;
    localparam logic [3:0] c_TENS_MAX     = 4'd5;
    localparam logic [3:0] c_H10_MAX      = 4'd2;
    localparam logic [3:0] c_H1_MAX_AT_20 = 4'd3;
    localparam bcd_time_t  c_TIME_ZERO    = 24'h000000;
    localparam bcd_time_t  c_TIME_ONE     = 24'h000001;

    function automatic logic bcd_time_valid(input bcd_time_t t);
        logic ok;
        ok = (t[23:20] <= c_H10_MAX)  && (t[19:16] <= c_DIGIT_MAX) &&
             (t[15:12] <= c_TENS_MAX) && (t[11:8]  <= c_DIGIT_MAX) &&
             (t[7:4]   <= c_TENS_MAX) && (t[3:0]   <= c_DIGIT_MAX);
        if ((t[23:20] == c_H10_MAX) && (t[19:16] > c_H1_MAX_AT_20)) begin
            ok = 1'b0;
        end
        if (t == c_TIME_ZERO) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic bcd_time_is_one(input bcd_time_t t);
        return (t == c_TIME_ONE);
    endfunction

endpackage : nap_timer_pkg
`default_nettype wire

// File: rtl/nap_timer_bank_if.sv
`default_nettype none
// ============================================================================
// Interface : nap_timer_bank_if
// Brief     : Command/readback bundle between keypad logic and the timer bank
// Revision  : 1.0 - initial release
// ============================================================================
interface nap_timer_bank_if #(
    parameter int CHANNELS = 2
) ();
    import nap_timer_pkg::*;

    localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS-1:0] write;
    bcd_time_t           set_time;
    logic [CHANNELS-1:0] start;
    logic [CHANNELS-1:0] pause;
    logic [CHANNELS-1:0] cancel;
    logic [CHANNELS-1:0] snooze;
    logic [SEL_W-1:0]    sel;
    bcd_time_t           get_time;
    logic [CHANNELS-1:0] running;
    logic [CHANNELS-1:0] ringing;
    logic [CHANNELS-1:0] complete;
    logic                set_err;

    modport master (
        output write, set_time, start, pause, cancel, snooze, sel,
        input  get_time, running, ringing, complete, set_err
    );

    modport slave (
        input  write, set_time, start, pause, cancel, snooze, sel,
        output get_time, running, ringing, complete, set_err
    );

endinterface : nap_timer_bank_if
`default_nettype wire

// File: rtl/nap_timer_channel.sv
`default_nettype none
// ============================================================================
// Module   : nap_timer_channel
// Brief    : One HH:MM:SS countdown: state machine, BCD decrementer, snooze count
// Config   : NAP_TIMER_SNOOZE_EN builds the snooze re-arm path
// Revision : 1.0 - initial release
// ============================================================================
module nap_timer_channel
    import nap_timer_pkg::*;
#(
    parameter int SNOOZE_MIN = 5,
    parameter int MAX_SNOOZE = 3
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_tick,
    input  logic      i_write,
    input  bcd_time_t i_set_time,
    input  logic      i_start,
    input  logic      i_pause,
    input  logic      i_cancel,
    input  logic      i_snooze,
    output bcd_time_t o_time,
    output logic      o_running,
    output logic      o_ringing,
    output logic      o_complete
);

    localparam logic [2:0] c_IDLE   = 3'(CH_IDLE);
    localparam logic [2:0] c_LOADED = 3'(CH_LOADED);
    localparam logic [2:0] c_RUN    = 3'(CH_RUN);
    localparam logic [2:0] c_PAUSE  = 3'(CH_PAUSE);
    localparam logic [2:0] c_RING   = 3'(CH_RING);

    logic [2:0] r_state;
    bcd_time_t  r_time;
    logic       r_complete;
    bcd_time_t  w_dec_time;
    logic       w_write_ok;
    logic       w_snooze_ok;

    // Ripple borrow from S1 upward; tens digits of minutes/seconds wrap to 5
    function automatic bcd_time_t bcd_dec(input bcd_time_t t);
        bcd_time_t r;
        logic      borrow;
        r      = t;
        borrow = 1'b1;
        for (int d = 0; d < 6; d++) begin
            if (borrow) begin
                if (t[4*d +: 4] != 4'd0) begin
                    r[4*d +: 4] = t[4*d +: 4] - 4'd1;
                    borrow      = 1'b0;
                end else begin
                    r[4*d +: 4] = ((d == 1) || (d == 3)) ? c_TENS_MAX : c_DIGIT_MAX;
                end
            end
        end
        return r;
    endfunction

    assign w_dec_time = bcd_dec(r_time);
    assign w_write_ok = i_write &&
                        ((r_state == c_IDLE) || (r_state == c_LOADED) || (r_state == c_PAUSE));

`ifdef NAP_TIMER_SNOOZE_EN
    localparam bcd_time_t c_SNOOZE_TIME = {8'h00, 4'(SNOOZE_MIN / 10), 4'(SNOOZE_MIN % 10), 8'h00};

    logic [3:0] r_snooze_cnt;

    assign w_snooze_ok = i_snooze && (r_state == c_RING) && (r_snooze_cnt < 4'(MAX_SNOOZE));

    always_ff @(posedge clk) begin
        if (!rst_n || i_cancel || w_write_ok) begin
            r_snooze_cnt <= 4'd0;
        end else if (w_snooze_ok) begin
            r_snooze_cnt <= r_snooze_cnt + 4'd1;
        end
    end
`else
    localparam bcd_time_t c_SNOOZE_TIME = c_TIME_ZERO;

    logic w_unused_snooze;

    assign w_snooze_ok     = 1'b0;
    assign w_unused_snooze = ^{i_snooze, 4'(MAX_SNOOZE), 6'(SNOOZE_MIN)};
`endif

    // Branch order is the command priority; an inapplicable command falls through
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_time     <= c_TIME_ZERO;
            r_complete <= 1'b0;
        end else begin
            r_complete <= 1'b0;
            if (i_cancel) begin
                r_state <= c_IDLE;
                r_time  <= c_TIME_ZERO;
            end else if (w_write_ok) begin
                r_state <= c_LOADED;
                r_time  <= i_set_time;
            end else if (w_snooze_ok) begin
                r_state <= c_RUN;
                r_time  <= c_SNOOZE_TIME;
            end else if (i_start && ((r_state == c_LOADED) || (r_state == c_PAUSE))) begin
                r_state <= c_RUN;
            end else if (i_pause && (r_state == c_RUN)) begin
                r_state <= c_PAUSE;
            end else if (i_tick && (r_state == c_RUN)) begin
                if (bcd_time_is_one(r_time)) begin
                    r_state    <= c_RING;
                    r_time     <= c_TIME_ZERO;
                    r_complete <= 1'b1;
                end else begin
                    r_time <= w_dec_time;
                end
            end
        end
    end

    assign o_time     = r_time;
    assign o_running  = (r_state == c_RUN);
    assign o_ringing  = (r_state == c_RING);
    assign o_complete = r_complete;

endmodule : nap_timer_channel
`default_nettype wire

// File: rtl/nap_timer_bank.sv
`default_nettype none
// ============================================================================
// Module   : nap_timer_bank
// Brief    : CHANNELS BCD countdown timers sharing one tick prescaler
// Config   : NAP_TIMER_SNOOZE_EN enables bounded snooze re-arm
// Revision : 1.0 - initial release
// ============================================================================
module nap_timer_bank
    import nap_timer_pkg::*;
#(
    parameter int CHANNELS   = 2,
    parameter int TICK_DIV   = 1000000,
    parameter int SNOOZE_MIN = 5,
    parameter int MAX_SNOOZE = 3
) (
    input  logic              clock,
    input  logic              reset,
    nap_timer_bank_if.slave   bus
);

    localparam int c_PRE_W = $clog2(TICK_DIV);

    logic [c_PRE_W-1:0]  r_prescale;
    logic                w_tick;
    logic                w_valid;
    logic                r_set_err;
    logic [CHANNELS-1:0] w_write_ok;
    logic [CHANNELS-1:0] w_running;
    logic [CHANNELS-1:0] w_ringing;
    logic [CHANNELS-1:0] w_complete;
    bcd_time_t           w_time [CHANNELS];
    bcd_time_t           w_get_time;

    assign w_tick = (r_prescale == c_PRE_W'(TICK_DIV - 1));

    always_ff @(posedge clock) begin
        if (!reset || w_tick) begin
            r_prescale <= '0;
        end else begin
            r_prescale <= r_prescale + 1'b1;
        end
    end

    // One shared check: a multi-channel write loads or rejects as a whole
    assign w_valid    = bcd_time_valid(bus.set_time);
    assign w_write_ok = bus.write & {CHANNELS{w_valid}};

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_set_err <= 1'b0;
        end else begin
            r_set_err <= (|bus.write) && !w_valid;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        nap_timer_channel #(
            .SNOOZE_MIN (SNOOZE_MIN),
            .MAX_SNOOZE (MAX_SNOOZE)
        ) u_chan (
            .clk        (clock),
            .rst_n      (reset),
            .i_tick     (w_tick),
            .i_write    (w_write_ok[g]),
            .i_set_time (bus.set_time),
            .i_start    (bus.start[g]),
            .i_pause    (bus.pause[g]),
            .i_cancel   (bus.cancel[g]),
            .i_snooze   (bus.snooze[g]),
            .o_time     (w_time[g]),
            .o_running  (w_running[g]),
            .o_ringing  (w_ringing[g]),
            .o_complete (w_complete[g])
        );
    end

    always_comb begin
        w_get_time = c_TIME_ZERO;
        for (int i = 0; i < CHANNELS; i++) begin
            if (int'(bus.sel) == i) begin
                w_get_time = w_time[i];
            end
        end
    end

    assign bus.get_time = w_get_time;
    assign bus.running  = w_running;
    assign bus.ringing  = w_ringing;
    assign bus.complete = w_complete;
    assign bus.set_err  = r_set_err;

endmodule : nap_timer_bank
`default_nettype wire
